// File: rtl/add_sub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
//   state_e       : controller states
//   MODE_ADD/SUB  : encoding of the Mode input
//   params_valid  : parameter legality check used at elaboration
package add_sub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Width must be at least 2 and split into a whole number of slices.
    function automatic bit params_valid(input int unsigned width, input int unsigned bpc);
        return (width >= 2) && (bpc >= 1) && (bpc <= width) && ((width % bpc) == 0);
    endfunction

endpackage : add_sub_pkg

// File: rtl/add_slice.sv
// Combinational ripple of BITS full adders.
//   a, b  : slice operands
//   cin   : carry into bit 0
//   s     : slice sum
//   cout  : carry out of the top bit
//   c_msb : carry into the top bit (for signed overflow detection)
module add_slice #(
    parameter int unsigned BITS = 1
) (
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    input  logic            cin,
    output logic [BITS-1:0] s,
    output logic            cout,
    output logic            c_msb
);

    logic [BITS:0] c;

    // Ripple chain: c[i] is the carry into bit i.
    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < int'(BITS); i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout  = c[BITS];
    assign c_msb = c[BITS-1];

endmodule : add_slice

// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor. Operands are captured on an accepted Start and
// consumed BITS_PER_CYCLE bits per clock; a one-cycle Done pulse reports the
// result, which is then held until the next completed operation.
//   clk, rst_n        : clock, asynchronous active-low reset
//   Start             : request strobe (ignored while Busy)
//   Mode              : 0 = add, 1 = subtract
//   Data_in_A/B       : operands, Data_in_C : carry-in / borrow-in
//   Busy              : operation in progress
//   Done              : one-cycle completion pulse
//   Data_out_Sum      : result
//   Data_out_Carry    : carry-out (add) or not-borrow (subtract)
//   Data_out_Overflow : two's-complement overflow
module serial_add_sub
    import add_sub_pkg::*;
#(
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Start,
    input  logic             Mode,
    input  logic [WIDTH-1:0] Data_in_A,
    input  logic [WIDTH-1:0] Data_in_B,
    input  logic             Data_in_C,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Data_out_Sum,
    output logic             Data_out_Carry,
    output logic             Data_out_Overflow
);

    localparam int unsigned N     = WIDTH / BITS_PER_CYCLE;
    localparam int unsigned CNT_W = $clog2(N + 1);

    if (!params_valid(WIDTH, BITS_PER_CYCLE)) begin : g_bad_params
        $error("serial_add_sub: WIDTH must be >= 2 and a multiple of BITS_PER_CYCLE");
    end

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   sum_out_q, sum_out_d;
    logic               carry_out_q, carry_out_d;
    logic               ovf_q, ovf_d;

    logic [BITS_PER_CYCLE-1:0] slice_s;
    logic                      slice_cout;
    logic                      slice_c_msb;
    logic [WIDTH-1:0]          res_next;
    logic                      capture;

    add_slice #(
        .BITS (BITS_PER_CYCLE)
    ) u_slice (
        .a     (a_q[BITS_PER_CYCLE-1:0]),
        .b     (b_q[BITS_PER_CYCLE-1:0]),
        .cin   (carry_q),
        .s     (slice_s),
        .cout  (slice_cout),
        .c_msb (slice_c_msb)
    );

    // Slice sum enters at the top; after N steps bit 0 of A lines up with bit 0 of the result.
    assign res_next = WIDTH'({slice_s, res_q} >> BITS_PER_CYCLE);

    // Next-state, datapath and output-register logic.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        sum_out_d   = sum_out_q;
        carry_out_d = carry_out_q;
        ovf_d       = ovf_q;
        capture     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                capture = Start;
            end
            ST_RUN: begin
                a_d     = a_q >> BITS_PER_CYCLE;
                b_d     = b_q >> BITS_PER_CYCLE;
                res_d   = res_next;
                carry_d = slice_cout;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_d == CNT_W'(N)) begin
                    state_d     = ST_DONE;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    sum_out_d   = res_next;
                    carry_out_d = slice_cout;
                    ovf_d       = slice_c_msb ^ slice_cout;
                end
            end
            ST_DONE: begin
                capture = Start;
                if (!Start) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Subtraction is A + ~B + ~C, so the carry-out reads as "no borrow".
        if (capture) begin
            state_d = ST_RUN;
            busy_d  = 1'b1;
            a_d     = Data_in_A;
            b_d     = (Mode == MODE_SUB) ? ~Data_in_B : Data_in_B;
            carry_d = (Mode == MODE_SUB) ? ~Data_in_C : Data_in_C;
            res_d   = '0;
            cnt_d   = '0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sum_out_q   <= '0;
            carry_out_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            sum_out_q   <= sum_out_d;
            carry_out_q <= carry_out_d;
            ovf_q       <= ovf_d;
        end
    end

    assign Busy              = busy_q;
    assign Done              = done_q;
    assign Data_out_Sum      = sum_out_q;
    assign Data_out_Carry    = carry_out_q;
    assign Data_out_Overflow = ovf_q;

endmodule : serial_add_sub
